arb_req_queue: RTL and testbench

- Upstream feeder for the two-requester round-robin arbiter.
- Buffers two independent producer streams in per-channel FIFOs and drives the arbiter's `request[1:0]` from FIFO occupancy.
- Consumes the arbiter's registered `grant[1:0]` to dequeue the granted channel's head entry onto a single merged output stream tagged with its channel.

---
 rtl/arb_pkg.sv | 15 +
 rtl/arb_chan_fifo.sv | 62 ++++++
 rtl/arb_req_queue.sv | 101 ++++++++++
 tb/tb_arb_req_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester arbiter front end and its benches.
package arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    typedef logic ch_t;

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/arb_chan_fifo.sv
// Single-channel synchronous FIFO with occupancy count; head is visible on
// rd_data whenever the FIFO is non-empty.
module arb_chan_fifo
    import arb_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int CNT_W  = cnt_width(DEPTH),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/arb_req_queue.sv
// Two-channel request queue in front of the round-robin arbiter: buffers
// producer data, raises requests from occupancy and dequeues on grant.
module arb_req_queue
    import arb_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  in_valid,
    output logic [NUM_REQ-1:0]  in_ready,
    input  logic [DATA_W-1:0]   in_data0,
    input  logic [DATA_W-1:0]   in_data1,
    output logic [NUM_REQ-1:0]  request,
    input  logic [NUM_REQ-1:0]  grant,
    output logic                out_valid,
    output logic                out_ch,
    output logic [DATA_W-1:0]   out_data,
    output logic                grant_err
);

    logic [DATA_W-1:0]  wr_data [NUM_REQ];
    logic [DATA_W-1:0]  rd_data [NUM_REQ];
    logic [CNT_W-1:0]   count   [NUM_REQ];
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] empty;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] empty_grant;
    logic               grant_fault;

    logic               out_valid_q, out_valid_d;
    ch_t                out_ch_q, out_ch_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               grant_err_q, grant_err_d;

    assign wr_data[0] = in_data0;
    assign wr_data[1] = in_data1;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chan
        assign in_ready[gi]    = ~full[gi];
        assign push[gi]        = in_valid[gi] & ~full[gi];
        // An in-flight grant already claims one entry, so it is not re-requested.
        assign request[gi]     = (count[gi] > CNT_W'(grant[gi]));
        assign pop[gi]         = grant[gi] & ~grant[NUM_REQ-1-gi] & ~empty[gi];
        assign empty_grant[gi] = grant[gi] & empty[gi];

        arb_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push    (push[gi]),
            .pop     (pop[gi]),
            .wr_data (wr_data[gi]),
            .rd_data (rd_data[gi]),
            .count   (count[gi]),
            .full    (full[gi]),
            .empty   (empty[gi])
        );
    end

    assign grant_fault = (&grant) | (|empty_grant);

    always_comb begin
        out_valid_d = |pop;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        grant_err_d = grant_err_q | grant_fault;
        if (pop[1]) begin
            out_ch_d   = 1'b1;
            out_data_d = rd_data[1];
        end else if (pop[0]) begin
            out_ch_d   = 1'b0;
            out_data_d = rd_data[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= 1'b0;
            out_data_q  <= '0;
            grant_err_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_arb_req_queue.sv
// Randomised scoreboard bench for arb_req_queue with a round-robin arbiter model.
module tb_arb_req_queue;
    import arb_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic       ch;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] in_valid = 2'b00;
    logic [1:0] in_ready;
    logic [7:0] in_data0 = 8'h00;
    logic [7:0] in_data1 = 8'h00;
    logic [1:0] request;
    logic [1:0] grant;
    logic       out_valid;
    logic       out_ch;
    logic [7:0] out_data;
    logic       grant_err;

    logic       force_en = 1'b1;
    logic [1:0] force_grant = 2'b00;
    logic [1:0] arb_grant_q;
    logic       arb_last;

    int n_checks = 0;
    int n_err = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    exp_t       sb[$];
    logic       model_err = 1'b0;
    logic       exp_last_ch = 1'b0;
    logic [7:0] exp_last_data = 8'h00;

    arb_req_queue #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .request   (request),
        .grant     (grant),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .grant_err (grant_err)
    );

    always #5 clk = ~clk;

    assign grant = force_en ? force_grant : arb_grant_q;

    // Registered round-robin arbiter attached to the request outputs.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_grant_q <= 2'b00;
            arb_last    <= 1'b1;
        end else if (request == 2'b11) begin
            arb_grant_q <= arb_last ? 2'b01 : 2'b10;
            arb_last    <= ~arb_last;
        end else if (request[0]) begin
            arb_grant_q <= 2'b01;
            arb_last    <= 1'b0;
        end else if (request[1]) begin
            arb_grant_q <= 2'b10;
            arb_last    <= 1'b1;
        end else begin
            arb_grant_q <= 2'b00;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: two bounded queues, expected outputs pushed to the scoreboard.
    always @(posedge clk) begin
        if (reset) begin
            int s0, s1;
            logic [7:0] d;
            s0 = q0.size();
            s1 = q1.size();
            if (grant == 2'b11 || (grant[0] && s0 == 0) || (grant[1] && s1 == 0))
                model_err = 1'b1;
            if (grant == 2'b01 && s0 > 0) begin
                d = q0.pop_front();
                sb.push_back({1'b0, d});
                exp_last_ch = 1'b0;
                exp_last_data = d;
            end
            if (grant == 2'b10 && s1 > 0) begin
                d = q1.pop_front();
                sb.push_back({1'b1, d});
                exp_last_ch = 1'b1;
                exp_last_data = d;
            end
            if (in_valid[0] && s0 < DEPTH) q0.push_back(in_data0);
            if (in_valid[1] && s1 < DEPTH) q1.push_back(in_data1);
        end
    end

    always @(negedge reset) begin
        q0.delete();
        q1.delete();
        sb.delete();
        model_err = 1'b0;
        exp_last_ch = 1'b0;
        exp_last_data = 8'h00;
    end

    // Monitor: compares every output once per cycle on the falling edge.
    always @(negedge clk) begin
        logic [1:0] er;
        logic [1:0] ereq;
        exp_t e;
        er[0]   = q0.size() < DEPTH;
        er[1]   = q1.size() < DEPTH;
        ereq[0] = q0.size() > int'(grant[0]);
        ereq[1] = q1.size() > int'(grant[1]);
        check("in_ready", in_ready, er);
        check("request", request, ereq);
        check("grant_err", grant_err, model_err);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out_valid", out_valid, 1'b1);
            check("out_ch", out_ch, e.ch);
            check("out_data", out_data, e.data);
        end else begin
            check("out_valid_idle", out_valid, 1'b0);
            check("out_ch_hold", out_ch, exp_last_ch);
            check("out_data_hold", out_data, exp_last_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        force_en = 1'b0;
        repeat (10) step();

        // Single entry on channel 0.
        in_valid = 2'b01;
        in_data0 = 8'hA1;
        step();
        in_valid = 2'b00;
        repeat (6) step();

        // Fill both channels with the arbiter held off, then drain.
        force_en = 1'b1;
        force_grant = 2'b00;
        for (int k = 0; k < 4; k++) begin
            in_valid = 2'b11;
            in_data0 = 8'(8'h10 + k);
            in_data1 = 8'(8'h20 + k);
            step();
        end
        in_valid = 2'b00;
        step();
        check("full_ready", in_ready, 2'b00);
        force_en = 1'b0;
        repeat (15) step();
        check("drained_request", request, 2'b00);

        // Push into a full channel while it is granted.
        force_en = 1'b1;
        force_grant = 2'b00;
        for (int k = 0; k < 4; k++) begin
            in_valid = 2'b01;
            in_data0 = 8'(8'h30 + k);
            step();
        end
        in_data0 = 8'h34;
        force_grant = 2'b01;
        step();
        force_grant = 2'b00;
        step();
        in_valid = 2'b00;
        check("refill_ready", in_ready[0], 1'b0);
        force_en = 1'b0;
        repeat (15) step();

        // Protocol errors: grant to an empty channel, then a double grant.
        force_en = 1'b1;
        force_grant = 2'b01;
        step();
        force_grant = 2'b00;
        step();
        check("err_set", grant_err, 1'b1);
        in_valid = 2'b11;
        in_data0 = 8'h55;
        in_data1 = 8'h66;
        step();
        in_valid = 2'b00;
        force_grant = 2'b11;
        step();
        force_grant = 2'b00;
        step();
        check("err_sticky", grant_err, 1'b1);
        check("req_after_double", request, 2'b11);
        force_en = 1'b0;
        repeat (10) step();

        // Random traffic with occasional forced grants.
        repeat (3000) begin
            in_valid = 2'($urandom_range(0, 3));
            in_data0 = 8'($urandom);
            in_data1 = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                force_en = 1'b1;
                force_grant = 2'($urandom_range(0, 3));
            end else begin
                force_en = 1'b0;
            end
            step();
        end
        in_valid = 2'b00;
        force_en = 1'b0;
        repeat (20) step();

        // Asynchronous reset with entries queued and a grant in flight.
        force_en = 1'b1;
        force_grant = 2'b00;
        for (int k = 0; k < 3; k++) begin
            in_valid = 2'b01;
            in_data0 = 8'(8'h70 + k);
            step();
        end
        in_valid = 2'b00;
        force_grant = 2'b01;
        step();
        check("pre_reset_valid", out_valid, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_grant_err", grant_err, 1'b0);
        check("rst_in_ready", in_ready, 2'b11);
        check("rst_request", request, 2'b00);
        step();
        step();
        reset = 1'b1;
        step();
        check("post_reset_err", grant_err, 1'b1);
        check("post_reset_data", out_data, 8'h00);
        force_grant = 2'b00;
        force_en = 1'b0;
        repeat (5) step();
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
